// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one sync memory port between the cpu (absolute priority) and a secondary dev master
module mem_arbiter #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic        dev_req,
  input  logic [29:0] dev_addr,
  input  logic [3:0]  dev_we,
  input  logic [31:0] dev_wdata,
  output logic        dev_gnt,
  output logic        dev_rvalid,
  output logic [31:0] dev_rdata,
  output logic        starved,
  output logic [29:0] mem_addr,
  output logic        mem_re,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [CNT_W-1:0] WMAX = CNT_W'(WAIT_MAX);
  logic             cpu_act, dev_rd, rd_pend;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  assign cpu_rdata = mem_rdata;
  always_comb begin
    cpu_act   = cpu_re | (|cpu_we);
    dev_gnt   = reset_n & dev_req & ~cpu_act;
    dev_rd    = dev_gnt & ~(|dev_we);
    mem_addr  = dev_gnt ? dev_addr : cpu_addr;
    mem_wdata = dev_gnt ? dev_wdata : cpu_wdata;
    mem_re    = reset_n & (cpu_act ? cpu_re : dev_rd);
    mem_we    = !reset_n ? 4'h0 : cpu_act ? cpu_we : dev_gnt ? dev_we : 4'h0;
    cnt_nxt   = (dev_req & ~dev_gnt) ? ((cnt == WMAX) ? cnt : cnt + 1'b1) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend    <= 1'b0;
      dev_rvalid <= 1'b0;
      dev_rdata  <= '0;
      cnt        <= '0;
      starved    <= 1'b0;
    end else begin
      rd_pend    <= dev_rd;
      dev_rvalid <= rd_pend;
      if (rd_pend) dev_rdata <= mem_rdata;
      cnt        <= cnt_nxt;
      starved    <= (cnt_nxt == WMAX);
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random + directed checks of mem_arbiter against a shadow-memory reference model
module tb_mem_arbiter;
  localparam int WAIT_MAX = 4;
  logic        clk = 0, reset_n = 0;
  logic [29:0] cpu_addr = 0, dev_addr = 0, mem_addr;
  logic        cpu_re = 0, dev_req = 0, dev_gnt, dev_rvalid, starved, mem_re;
  logic [3:0]  cpu_we = 0, dev_we = 0, mem_we;
  logic [31:0] cpu_wdata = 0, dev_wdata = 0, cpu_rdata, dev_rdata, mem_wdata, mem_rdata;
  logic        load = 1;
  logic [31:0] ram [64];
  logic [31:0] sh [64];
  typedef struct {int due; logic [31:0] d;} rd_t;
  rd_t         q[$];
  int          cyc = 0, waited = 0, total = 0, passed = 0;
  logic        cpu_pend = 0;
  logic [31:0] cpu_exp = 0, last_rd = 0;

  mem_arbiter #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dev_req(dev_req), .dev_addr(dev_addr), .dev_we(dev_we), .dev_wdata(dev_wdata),
    .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata), .starved(starved),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) ram[i] <= sh[i];
    end else begin
      if (mem_re) mem_rdata <= ram[mem_addr[5:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    else passed++;
  endtask

  task automatic step(input bit rst, input bit cre, input logic [3:0] cwe, input logic [29:0] ca,
                      input logic [31:0] cwd, input bit dreq, input logic [3:0] dwe,
                      input logic [29:0] da, input logic [31:0] dwd);
    bit act, gnt, exp_v;
    logic [3:0] w;
    logic [29:0] wa;
    logic [31:0] wd;
    reset_n = rst; cpu_re = cre; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dev_req = dreq; dev_we = dwe; dev_addr = da; dev_wdata = dwd;
    @(negedge clk);
    act = cre || (cwe != 0);
    gnt = rst && dreq && !act;
    if (!rst) begin q.delete(); last_rd = 0; waited = 0; end
    exp_v = 0;
    if (q.size() > 0 && q[0].due == cyc) begin exp_v = 1; last_rd = q[0].d; void'(q.pop_front()); end
    chk("dev_gnt", 32'(dev_gnt), 32'(gnt));
    chk("mem_re", 32'(mem_re), 32'(rst && (act ? cre : (gnt && dwe == 0))));
    chk("mem_we", 32'(mem_we), !rst ? 0 : act ? 32'(cwe) : gnt ? 32'(dwe) : 0);
    chk("mem_addr", 32'(mem_addr), gnt ? 32'(da) : 32'(ca));
    chk("mem_wdata", mem_wdata, gnt ? dwd : cwd);
    chk("dev_rvalid", 32'(dev_rvalid), 32'(exp_v));
    chk("dev_rdata", dev_rdata, last_rd);
    chk("starved", 32'(starved), 32'(rst && waited >= WAIT_MAX));
    if (cpu_pend) chk("cpu_rdata", cpu_rdata, cpu_exp);
    cpu_pend = rst && act && cre;
    if (cpu_pend) cpu_exp = sh[ca[5:0]];
    if (gnt && dwe == 0) q.push_back('{cyc + 2, sh[da[5:0]]});
    w  = !rst ? 4'h0 : act ? cwe : gnt ? dwe : 4'h0;
    wa = act ? ca : da;
    wd = act ? cwd : dwd;
    for (int b = 0; b < 4; b++) if (w[b]) sh[wa[5:0]][8*b +: 8] = wd[8*b +: 8];
    waited = (rst && dreq && !gnt) ? waited + 1 : 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit dreq, cre;
    logic [3:0] dwe, cwe;
    logic [29:0] da, ca;
    logic [31:0] dwd, cwd;
    for (int i = 0; i < 64; i++) sh[i] = $urandom;
    sh[16] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 load = 0;
    step(0, 0, 0, 0, 0, 1, 0, 30'h10, 0);
    step(1, 0, 0, 0, 0, 1, 0, 30'h10, 0);
    idle(3);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 30'h20, 0, 1, 4'hF, 30'h21, 32'h55);
    step(1, 0, 0, 30'h20, 0, 1, 4'hF, 30'h21, 32'h55);
    idle(2);
    step(1, 0, 0, 0, 0, 1, 0, 30'h21, 0);
    step(1, 1, 0, 30'h30, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 30'h8, 0, 1, 0, 30'h7, 0);
    step(1, 0, 0, 0, 0, 1, 0, 30'h7, 0);
    idle(3);
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 0, 1, 0, 30'(i), 0);
    idle(3);
    step(1, 0, 0, 0, 0, 1, 0, 30'h10, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    dreq = 0; dwe = 0; da = 0; dwd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!dreq || $urandom_range(0, 7) == 0) begin
        dreq = $urandom_range(0, 3) != 0;
        dwe  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        da   = 30'($urandom_range(0, 63));
        dwd  = $urandom;
      end
      cre = $urandom_range(0, 2) == 0;
      cwe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ca  = 30'($urandom_range(0, 63));
      cwd = $urandom;
      step(1, cre, cwe, ca, cwd, dreq, dwe, da, dwd);
      if (dreq && !(cre || cwe != 0)) dreq = 0;
    end
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
